// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types and constants for the Morse letter capture block
//
// Holds the capture FSM state encoding, the symbol encoding stored in the
// code word (DOT=0, DASH=1) and the default number of symbols per letter.
package morse_pkg;

  // Default maximum symbols per letter (width of the code word).
  localparam int MORSE_MAX_SYM = 5;

  // Symbol value as stored in the code word.
  typedef enum logic {
    SYM_DOT  = 1'b0,
    SYM_DASH = 1'b1
  } morse_sym_e;

  // Capture FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } morse_state_e;

endpackage

// File: rtl/morse_edge_det.sv
// rtl/morse_edge_det.sv - rising-edge detector for one synchronous key level
//
// Registers the previous key level and emits a one-cycle event when the key
// is 1 and the registered previous level is 0. The previous-level register
// resets to 0, so a key already held high when reset releases produces an
// event on the first cycle.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   key_i    - key level, already synchronous to clk
//   event_o  - combinational one-cycle rising-edge pulse
module morse_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic event_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= key_i;
    end
  end

  assign event_o = key_i & ~prev_q;

endmodule

// File: rtl/morse_capture_ctrl.sv
// rtl/morse_capture_ctrl.sv - captures dot/dash key presses into a Morse letter with valid/ready output
//
// Optional feature macro: MORSE_TIMEOUT_EN
//   defined   - a letter in collection is also closed after GAP_CYCLES
//               consecutive cycles without a key event.
//   undefined - a letter closes only when full or on end_in.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   dot_in     - dot key level (synchronous)
//   dash_in    - dash key level (synchronous)
//   end_in     - single-cycle request to close the current letter
//   code       - captured symbols, first symbol in MSB, dash=1, dot=0
//   len        - number of valid symbols in code
//   code_valid - letter available (HOLD state)
//   code_ready - consumer accepts the letter
//   drop       - one-cycle pulse when a key edge was discarded
module morse_capture_ctrl
  import morse_pkg::*;
#(
  parameter int MAX_SYM    = MORSE_MAX_SYM,
  parameter int GAP_CYCLES = 1000,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dot_in,
  input  logic               dash_in,
  input  logic               end_in,
  output logic [MAX_SYM-1:0] code,
  output logic [2:0]         len,
  output logic               code_valid,
  input  logic               code_ready,
  output logic               drop
);

  // Elaboration-time guards on the configuration.
  if (MAX_SYM < 1 || MAX_SYM > 7) begin : g_bad_max_sym
    $error("MAX_SYM must be in 1..7 to fit the 3-bit len output");
  end
  if (GAP_CYCLES < 1 || longint'(GAP_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_gap
    $error("GAP_CYCLES must be at least 1 and fit in CNT_W bits");
  end

  localparam logic [2:0] LEN_FULL = 3'(MAX_SYM);

  morse_state_e       state_q, state_d;
  logic [MAX_SYM-1:0] code_q, code_d;
  logic [2:0]         len_q, len_d;
  logic               drop_q, drop_d;

  logic       dot_ev, dash_ev, key_ev, both_ev;
  morse_sym_e sym;

  morse_edge_det u_dot_edge (
    .clk     (clk),
    .rst_n   (reset),
    .key_i   (dot_in),
    .event_o (dot_ev)
  );

  morse_edge_det u_dash_edge (
    .clk     (clk),
    .rst_n   (reset),
    .key_i   (dash_in),
    .event_o (dash_ev)
  );

  assign key_ev  = dot_ev | dash_ev;
  assign both_ev = dot_ev & dash_ev;
  // A simultaneous dot and dash resolves to a dash; the dot is the dropped edge.
  assign sym     = dash_ev ? SYM_DASH : SYM_DOT;

`ifdef MORSE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  logic [CNT_W-1:0] gap_q, gap_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      len_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
      drop_q  <= drop_d;
    end
  end

`ifdef MORSE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    len_d   = len_q;
    drop_d  = 1'b0;
`ifdef MORSE_TIMEOUT_EN
    // The gap counter only runs while collecting; every other path clears it.
    gap_d   = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (key_ev) begin
          code_d[MAX_SYM-1] = sym;
          len_d             = 3'd1;
          drop_d            = both_ev;
          state_d           = (len_d == LEN_FULL) ? ST_HOLD : ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (key_ev) begin
          // Next free slot counts down from the MSB.
          for (int i = 0; i < MAX_SYM; i++) begin
            if (i == MAX_SYM - 1 - int'(len_q)) begin
              code_d[i] = sym;
            end
          end
          len_d  = len_q + 3'd1;
          drop_d = both_ev;
          if (len_d == LEN_FULL || end_in) begin
            state_d = ST_HOLD;
          end
        end else if (end_in) begin
          state_d = ST_HOLD;
        end
`ifdef MORSE_TIMEOUT_EN
        else if (gap_q == GAP_LAST) begin
          state_d = ST_HOLD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
`endif
      end

      ST_HOLD: begin
        // The letter is frozen; any new key edge is lost, including on the
        // handshake cycle.
        drop_d = key_ev;
        if (code_ready) begin
          state_d = ST_IDLE;
          code_d  = '0;
          len_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        code_d  = '0;
        len_d   = '0;
      end
    endcase
  end

  assign code       = code_q;
  assign len        = len_q;
  assign code_valid = (state_q == ST_HOLD);
  assign drop       = drop_q;

endmodule

// File: tb/tb_morse_capture_ctrl.sv
// tb/tb_morse_capture_ctrl.sv - self-checking bench for morse_capture_ctrl
module tb_morse_capture_ctrl;

  localparam int MAX_SYM = 5;
  localparam int GAP     = 8;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               dot_in, dash_in, end_in, code_ready;
  logic [MAX_SYM-1:0] code;
  logic [2:0]         len;
  logic               code_valid, drop;

  always #5 clk = ~clk;

  morse_capture_ctrl #(
    .MAX_SYM    (MAX_SYM),
    .GAP_CYCLES (GAP),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dot_in     (dot_in),
    .dash_in    (dash_in),
    .end_in     (end_in),
    .code       (code),
    .len        (len),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .drop       (drop)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: the letter is a list of symbols plus a "closed" flag.
  int m_syms[$];
  bit m_closed;
  bit m_drop;
  bit m_pdot, m_pdash;
  int m_gap;

  task automatic model_reset();
    m_syms.delete();
    m_closed = 0;
    m_drop   = 0;
    m_pdot   = 0;
    m_pdash  = 0;
    m_gap    = 0;
  endtask

  task automatic model_step(input bit d, input bit a, input bit e, input bit r);
    bit dev, aev, ev;
    dev    = d & !m_pdot;
    aev    = a & !m_pdash;
    ev     = dev | aev;
    m_pdot = d;
    m_pdash = a;
    m_drop = 0;
    if (m_closed) begin
      m_drop = ev;
      if (r) begin
        m_syms.delete();
        m_closed = 0;
      end
    end else if (ev) begin
      m_syms.push_back(aev ? 1 : 0);
      m_drop = dev & aev;
      m_gap  = 0;
      if (m_syms.size() == MAX_SYM || (m_syms.size() > 1 && e)) m_closed = 1;
    end else if (m_syms.size() > 0) begin
      if (e) m_closed = 1;
`ifdef MORSE_TIMEOUT_EN
      else if (m_gap == GAP - 1) m_closed = 1;
      else m_gap++;
`endif
    end
    if (!m_closed && m_syms.size() > 0 && ev) m_gap = 0;
  endtask

  function automatic logic [31:0] m_code();
    logic [31:0] c;
    c = '0;
    for (int k = 0; k < m_syms.size(); k++) begin
      if (m_syms[k] != 0) c[MAX_SYM-1-k] = 1'b1;
    end
    return c;
  endfunction

  task automatic check_model(input string tag);
    check_eq({tag, "_code"},  32'(code),       m_code());
    check_eq({tag, "_len"},   32'(len),        32'(m_syms.size()));
    check_eq({tag, "_valid"}, 32'(code_valid), 32'(m_closed));
    check_eq({tag, "_drop"},  32'(drop),       32'(m_drop));
  endtask

  task automatic drive(input bit d, input bit a, input bit e, input bit r);
    dot_in     = d;
    dash_in    = a;
    end_in     = e;
    code_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_step(dot_in, dash_in, end_in, code_ready);
    #1;
    check_model("cyc");
  endtask

  task automatic tap(input bit d, input bit a);
    drive(d, a, 1'b0, code_ready);
    step();
    drive(1'b0, 1'b0, 1'b0, code_ready);
    step();
  endtask

  task automatic hard_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_code",  32'(code),       32'd0);
    check_eq("rst_len",   32'(len),        32'd0);
    check_eq("rst_valid", 32'(code_valid), 32'd0);
    check_eq("rst_drop",  32'(drop),       32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int first;
    int exp_first;
    reset = 1'b1;
    drive(0, 0, 0, 0);
    #2;
    hard_reset();
    check_model("post_rst");

    // dot,dash,dot,dot,dash with ready held high
    code_ready = 1'b1;
    tap(0, 0);
    tap(1, 0);
    tap(0, 1);
    tap(1, 0);
    tap(1, 0);
    drive(0, 1, 0, 1);
    step();
    check_eq("r32_code",  32'(code),       32'b01001);
    check_eq("r32_len",   32'(len),        32'd5);
    check_eq("r32_valid", 32'(code_valid), 32'd1);
    drive(0, 0, 0, 1);
    step();
    check_eq("r32_valid_gone", 32'(code_valid), 32'd0);
    check_eq("r32_len_clr",    32'(len),        32'd0);

    // dash,dash,end with ready low for 10 cycles
    drive(0, 0, 0, 0);
    tap(0, 1);
    tap(0, 1);
    drive(0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("r33_code_hold", 32'(code), 32'b11000);
      check_eq("r33_len_hold",  32'(len),  32'd2);
    end
    drive(0, 0, 0, 1);
    step();
    check_eq("r33_code_clr", 32'(code),       32'd0);
    check_eq("r33_valid_clr", 32'(code_valid), 32'd0);

    // simultaneous dot and dash in IDLE
    drive(1, 1, 0, 0);
    step();
    check_eq("r34_code", 32'(code), 32'b10000);
    check_eq("r34_len",  32'(len),  32'd1);
    check_eq("r34_drop", 32'(drop), 32'd1);
    drive(0, 0, 0, 0);
    step();
    check_eq("r34_drop_once", 32'(drop), 32'd0);
    drive(0, 0, 1, 0);
    step();
    // dot event while holding
    drive(1, 0, 0, 0);
    step();
    check_eq("r35_drop", 32'(drop), 32'd1);
    check_eq("r35_code", 32'(code), 32'b10000);
    check_eq("r35_len",  32'(len),  32'd1);
    drive(0, 0, 0, 1);
    step();

    // single dot then idle: timeout behaviour
    drive(1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0);
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (code_valid && first < 0) first = i;
    end
`ifdef MORSE_TIMEOUT_EN
    exp_first = GAP;
`else
    exp_first = -1;
`endif
    check_eq("r36_timeout_at", 32'(first), 32'(exp_first));
    check_eq("r36_len", 32'(len), 32'd1);
    drive(0, 0, 1, 1);
    step();
    drive(0, 0, 0, 1);
    step();
    step();

    // reset in the middle of a letter
    drive(0, 0, 0, 0);
    tap(1, 0);
    tap(0, 1);
    tap(1, 0);
    hard_reset();
    drive(0, 1, 0, 0);
    step();
    check_eq("r37_code", 32'(code), 32'b10000);
    check_eq("r37_len",  32'(len),  32'd1);
    drive(0, 0, 1, 1);
    step();
    step();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) hard_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
